// File: rtl/objects_pkg.sv
// Shared types and helpers for the arrow collision logic.
// Holds the hit FSM encoding and the ball-index priority encoder.
package objects_pkg;

    localparam int MAX_BALLS = 8;

    typedef enum logic {
        SCAN = 1'b0,
        REQ  = 1'b1
    } hit_st_t;

    // Lowest set bit wins, so the first ball in index order is the one split.
    function automatic logic [2:0] lowest_set_idx(input logic [MAX_BALLS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_BALLS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arrow_hit_ctrl_hit_latch_bank.sv
// Sticky OR latches, one per ball plus one for the top border; updated one clock after the pixel.
// No backpressure: clear has priority over set, and set only accumulates while enabled.
module hit_latch_bank #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [N-1:0] i_set,
    output logic [N-1:0] o_hits
);

    logic [N-1:0] r_hits;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_hits <= '0;
        end else if (i_en) begin
            r_hits <= r_hits | i_set;
        end
    end

    assign o_hits = r_hits;

endmodule

// File: rtl/arrow_hit_ctrl.sv
// Arrow collision responder: latches frame hits, crash/scoreInc one clock after startOfFrame.
// splitReq is held until splitAck or ACK_TIMEOUT REQ clocks; hits and frames are ignored meanwhile.
module arrow_hit_ctrl
    import objects_pkg::*;
#(
    parameter int NUM_BALLS   = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 arrowDR,
    input  logic [NUM_BALLS-1:0] ballDR,
    input  logic                 topBorderDR,
    input  logic                 splitAck,
    output logic                 crash,
    output logic                 splitReq,
    output logic [2:0]           splitIdx,
    output logic                 scoreInc,
    output logic                 ackTimeoutErr
);

    localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    hit_st_t            r_state;
    logic               r_crash;
    logic               r_split_req;
    logic [2:0]         r_split_idx;
    logic               r_score_inc;
    logic               r_ack_err;
    logic [CNT_W-1:0]   r_cnt;

    logic                 w_in_scan;
    logic                 w_clr;
    logic [NUM_BALLS:0]   w_set;
    logic [NUM_BALLS:0]   w_hits;
    logic [NUM_BALLS-1:0] w_ball_hits;
    logic                 w_border_hit;
    logic [MAX_BALLS-1:0] w_ball_ext;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_timeout;

    assign w_in_scan = (r_state == SCAN);
    // Latches are held clear outside SCAN and cleared by the frame edge that evaluates them.
    assign w_clr     = ~w_in_scan | startOfFrame;
    assign w_set     = {arrowDR & topBorderDR, {NUM_BALLS{arrowDR}} & ballDR};

    hit_latch_bank #(
        .N (NUM_BALLS + 1)
    ) u_hit_latch_bank (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_in_scan),
        .i_set  (w_set),
        .o_hits (w_hits)
    );

    assign w_ball_hits  = w_hits[NUM_BALLS-1:0];
    assign w_border_hit = w_hits[NUM_BALLS];
    assign w_ball_ext   = MAX_BALLS'(w_ball_hits);

    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_nxt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_crash     <= 1'b0;
            r_split_req <= 1'b0;
            r_split_idx <= '0;
            r_score_inc <= 1'b0;
            r_ack_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_crash     <= 1'b0;
            r_score_inc <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (startOfFrame) begin
                        if (|w_ball_hits) begin
                            r_crash     <= 1'b1;
                            r_score_inc <= 1'b1;
                            r_split_idx <= lowest_set_idx(w_ball_ext);
                            r_split_req <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= REQ;
                        end else if (w_border_hit) begin
                            r_crash <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (splitAck) begin
                        r_split_req <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= SCAN;
                    end else if (w_timeout) begin
                        r_split_req <= 1'b0;
                        r_ack_err   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= SCAN;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign crash         = r_crash;
    assign splitReq      = r_split_req;
    assign splitIdx      = r_split_idx;
    assign scoreInc      = r_score_inc;
    assign ackTimeoutErr = r_ack_err;

endmodule

// File: tb/tb_arrow_hit_ctrl.sv
// Scoreboard bench for arrow_hit_ctrl: expected crash events queued at startOfFrame,
// popped and compared when the DUT pulses crash.
module tb_arrow_hit_ctrl;

    localparam int NB  = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          startOfFrame = 1'b0;
    logic          arrowDR = 1'b0;
    logic [NB-1:0] ballDR = '0;
    logic          topBorderDR = 1'b0;
    logic          splitAck = 1'b0;
    logic          crash;
    logic          splitReq;
    logic [2:0]    splitIdx;
    logic          scoreInc;
    logic          ackTimeoutErr;

    typedef struct {
        logic       score;
        logic [2:0] idx;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic m_req    = 1'b0;
    logic prev_crash = 1'b0;
    logic prev_score = 1'b0;

    arrow_hit_ctrl #(
        .NUM_BALLS   (NB),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .arrowDR       (arrowDR),
        .ballDR        (ballDR),
        .topBorderDR   (topBorderDR),
        .splitAck      (splitAck),
        .crash         (crash),
        .splitReq      (splitReq),
        .splitIdx      (splitIdx),
        .scoreInc      (scoreInc),
        .ackTimeoutErr (ackTimeoutErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] first_ball(input logic [NB-1:0] m);
        int r;
        r = 0;
        while (r < NB && !m[r]) r++;
        return 3'(r);
    endfunction

    // Drives npix overlapping pixels, two idle pixels, then startOfFrame.
    task automatic frame(input logic arrow, input logic [NB-1:0] mask,
                         input logic border, input int npix);
        exp_t e;
        arrowDR = arrow; ballDR = mask; topBorderDR = border;
        repeat (npix) tick();
        arrowDR = 1'b0; ballDR = '0; topBorderDR = 1'b0;
        tick();
        tick();
        if (!m_req && arrow && npix > 0) begin
            if (mask != '0) begin
                e.score = 1'b1;
                e.idx   = first_ball(mask);
                q_exp.push_back(e);
                m_req = 1'b1;
            end else if (border) begin
                e.score = 1'b0;
                e.idx   = 3'd0;
                q_exp.push_back(e);
            end
        end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    always @(negedge clk) begin
        if (prev_crash) chk("crash_width", 32'(crash), 0);
        if (prev_score) chk("score_width", 32'(scoreInc), 0);
        if (scoreInc && !crash) chk("score_without_crash", 32'(scoreInc), 32'(crash));
        if (crash) begin
            if (q_exp.size() == 0) begin
                chk("crash_unexpected", 32'(crash), 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("crash_score", 32'(scoreInc), 32'(e.score));
                chk("crash_req", 32'(splitReq), 32'(e.score));
                if (e.score) chk("crash_idx", 32'(splitIdx), 32'(e.idx));
            end
        end
        prev_crash = crash;
        prev_score = scoreInc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        repeat (3) tick();
        chk("rst_crash", 32'(crash), 0);
        chk("rst_req", 32'(splitReq), 0);
        chk("rst_idx", 32'(splitIdx), 0);
        chk("rst_score", 32'(scoreInc), 0);
        chk("rst_err", 32'(ackTimeoutErr), 0);
        reset = 1'b0;
        tick();

        // Border only: one crash, no score, no request.
        frame(1'b1, 4'b0000, 1'b1, 5);
        chk("border_no_req", 32'(splitReq), 0);
        tick();
        tick();

        // Ack in SCAN must be ignored.
        splitAck = 1'b1;
        tick();
        splitAck = 1'b0;
        chk("ack_in_scan", 32'(splitReq), 0);

        // Ball 2 hit, ack sampled seven clocks after the frame edge.
        frame(1'b1, 4'b0100, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            chk("b2_req_held", 32'(splitReq), 1);
            chk("b2_idx_held", 32'(splitIdx), 2);
            tick();
        end
        chk("b2_req_before_ack", 32'(splitReq), 1);
        splitAck = 1'b1;
        tick();
        splitAck = 1'b0;
        m_req = 1'b0;
        chk("b2_req_dropped", 32'(splitReq), 0);
        chk("b2_no_err", 32'(ackTimeoutErr), 0);
        tick();

        // Balls 1 and 3 plus border in one frame.
        frame(1'b1, 4'b1010, 1'b1, 4);
        chk("multi_idx", 32'(splitIdx), 1);
        repeat (2) tick();
        splitAck = 1'b1;
        tick();
        splitAck = 1'b0;
        m_req = 1'b0;
        chk("multi_req_dropped", 32'(splitReq), 0);
        tick();

        // Ball 0, never acked: request lives for exactly TMO clocks.
        frame(1'b1, 4'b0001, 1'b0, 2);
        c = 0;
        while (splitReq === 1'b1 && c < 40) begin
            c++;
            tick();
        end
        chk("timeout_len", 32'(c), 32'(TMO));
        chk("timeout_err", 32'(ackTimeoutErr), 1);
        m_req = 1'b0;
        tick();
        frame(1'b1, 4'b0000, 1'b1, 2);
        tick();
        chk("err_sticky", 32'(ackTimeoutErr), 1);

        // Hits and frame edge during REQ produce nothing.
        frame(1'b1, 4'b0001, 1'b0, 2);
        frame(1'b1, 4'b0100, 1'b1, 3);
        chk("req_still_held", 32'(splitReq), 1);
        chk("req_idx_stable", 32'(splitIdx), 0);
        splitAck = 1'b1;
        tick();
        splitAck = 1'b0;
        m_req = 1'b0;
        chk("req5_dropped", 32'(splitReq), 0);
        frame(1'b0, 4'b1111, 1'b1, 4);
        tick();
        tick();

        // Reset in the middle of a handshake.
        frame(1'b1, 4'b1000, 1'b0, 2);
        tick();
        chk("pre_rst_req", 32'(splitReq), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_req = 1'b0;
        chk("midrst_req", 32'(splitReq), 0);
        chk("midrst_crash", 32'(crash), 0);
        chk("midrst_score", 32'(scoreInc), 0);
        chk("midrst_err", 32'(ackTimeoutErr), 0);
        chk("midrst_idx", 32'(splitIdx), 0);
        frame(1'b0, 4'b0000, 1'b0, 3);
        tick();
        tick();

        chk("sb_empty", 32'(q_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
